// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register: owns PCF, drives a single-outstanding
// variable-latency instruction-memory handshake and feeds decode, bubbling when memory is slow.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stallF,
   input  logic        stallD,
   input  logic        FlushD,
   input  logic        PcSrcE,
   input  logic [31:0] PcTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   output logic        fetch_pending,
   output logic [1:0]  state_dbg
);

   // Handshake: imem_req/imem_addr form a request that, once raised, stays asserted with a
   // stable address until the cycle imem_rvalid = 1 (same cycle or later); imem_rvalid with
   // imem_req = 0 is ignored. At most one request is outstanding.

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state, state_n;
   logic        pending;
   logic [31:0] pcf, pcf_n;
   logic [31:0] req_addr;
   logic [31:0] buf_q;
   logic        resp;
   logic        available;
   logic        consume;
   logic [31:0] word;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_n;
   end

   // Next-state logic; a redirect overrides everything else
   always_comb begin
      state_n = state;
      if (PcSrcE) begin
         state_n = (imem_req && !imem_rvalid) ? DRAIN : FETCH;
      end else begin
         case (state)
            FETCH:   if (resp && !consume) state_n = HOLD;
            HOLD:    if (consume)          state_n = FETCH;
            DRAIN:   if (resp)             state_n = FETCH;
            default: state_n = FETCH;
         endcase
      end
   end

   // Output / handshake logic
   always_comb begin
      imem_req      = !reset && (pending || (state == FETCH && !stallF));
      imem_addr     = pending ? req_addr : pcf;
      fetch_pending = imem_req;
      state_dbg     = state;
      resp          = imem_req && imem_rvalid;
      available     = (state == HOLD) || (state == FETCH && resp);
      word          = (state == HOLD) ? buf_q : imem_rdata;
      consume       = available && !stallD && !FlushD && !PcSrcE;
      pcf_n         = pcf;
      if (PcSrcE)       pcf_n = {PcTargetE[31:2], 2'b00};
      else if (consume) pcf_n = pcf + 32'd4;
   end

   // Request bookkeeping: the launch address is latched so a redirect cannot move it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcf      <= RESET_PC;
         pending  <= 1'b0;
         req_addr <= RESET_PC;
         buf_q    <= NOP_INSTR;
      end else begin
         pcf     <= pcf_n;
         pending <= imem_req && !imem_rvalid;
         if (imem_req && !pending) req_addr <= pcf;
         if (state == FETCH && resp && !consume && !PcSrcE) buf_q <= imem_rdata;
      end
   end

   // IF/ID register: flush beats stall; bubbles keep PCD/PCPlus4D
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         InstrD   <= NOP_INSTR;
         PCD      <= 32'd0;
         PCPlus4D <= 32'd0;
         ValidD   <= 1'b0;
      end else if (FlushD) begin
         InstrD <= NOP_INSTR;
         ValidD <= 1'b0;
      end else if (consume) begin
         InstrD   <= word;
         PCD      <= pcf;
         PCPlus4D <= pcf + 32'd4;
         ValidD   <= 1'b1;
      end else if (!stallD) begin
         InstrD <= NOP_INSTR;
         ValidD <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle vectors plus hand-written
// sequences for latency, hold, drain and asynchronous reset.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stallF = 1'b0, stallD = 1'b0, FlushD = 1'b0, PcSrcE = 1'b0;
   logic [31:0] PcTargetE = 32'd0;
   logic        imem_req, imem_rvalid, ValidD, fetch_pending;
   logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   int lat = 0;
   int wait_cnt;
   logic spurious = 1'b0;

   fetch_stage dut (
      .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .FlushD(FlushD),
      .PcSrcE(PcSrcE), .PcTargetE(PcTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
      .PCPlus4D(PCPlus4D), .ValidD(ValidD), .fetch_pending(fetch_pending), .state_dbg(state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return 32'hC0DE_0000 | {16'h0000, a[15:0]};
   endfunction

   // Memory model: answers after lat cycles of an asserted request
   assign imem_rvalid = spurious || (imem_req && (wait_cnt == lat));
   assign imem_rdata  = word_of(imem_addr);
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                         wait_cnt <= 0;
      else if (imem_req && !imem_rvalid) wait_cnt <= wait_cnt + 1;
      else                               wait_cnt <= 0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic sf, input logic sd, input logic fd, input logic ps,
                         input logic [31:0] tgt);
      stallF = sf; stallD = sd; FlushD = fd; PcSrcE = ps; PcTargetE = tgt;
   endtask

   task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] instr);
      check({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, v});
      check({tag, ".PCD"}, PCD, pc);
      check({tag, ".PCPlus4D"}, PCPlus4D, pc + 32'd4);
      check({tag, ".InstrD"}, InstrD, instr);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".imem_req"}, {31'd0, imem_req}, 32'd0);
      check({tag, ".fetch_pending"}, {31'd0, fetch_pending}, 32'd0);
      check({tag, ".ValidD"}, {31'd0, ValidD}, 32'd0);
      check({tag, ".InstrD"}, InstrD, NOP);
      check({tag, ".PCD"}, PCD, 32'd0);
      check({tag, ".PCPlus4D"}, PCPlus4D, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_in(0, 0, 0, 0, 32'd0);
      step();
      step();
      check_reset_vals("reset");
      check("reset.state", {30'd0, state_dbg}, 32'd0);
      reset = 1'b0;
   endtask

   typedef struct packed {
      logic        sf, sd, fd, ps;
      logic [31:0] tgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vecs[13];

   initial begin
      // Zero-latency memory unless noted; e_* are this cycle's request and IF/ID after the edge
      vecs[0]  = '{0, 0, 0, 0, 32'h0,   1, 32'h00,  1, 32'h00,  word_of(32'h00)};
      vecs[1]  = '{0, 0, 0, 0, 32'h0,   1, 32'h04,  1, 32'h04,  word_of(32'h04)};
      vecs[2]  = '{0, 0, 0, 0, 32'h0,   1, 32'h08,  1, 32'h08,  word_of(32'h08)};
      vecs[3]  = '{0, 0, 0, 0, 32'h0,   1, 32'h0C,  1, 32'h0C,  word_of(32'h0C)};
      vecs[4]  = '{0, 1, 0, 0, 32'h0,   1, 32'h10,  1, 32'h0C,  word_of(32'h0C)};
      vecs[5]  = '{0, 1, 0, 0, 32'h0,   0, 32'h10,  1, 32'h0C,  word_of(32'h0C)};
      vecs[6]  = '{0, 0, 0, 0, 32'h0,   0, 32'h10,  1, 32'h10,  word_of(32'h10)};
      vecs[7]  = '{0, 0, 1, 0, 32'h0,   1, 32'h14,  0, 32'h10,  NOP};
      vecs[8]  = '{0, 0, 0, 0, 32'h0,   0, 32'h14,  1, 32'h14,  word_of(32'h14)};
      vecs[9]  = '{0, 0, 0, 0, 32'h0,   1, 32'h18,  1, 32'h18,  word_of(32'h18)};
      vecs[10] = '{1, 0, 0, 0, 32'h0,   0, 32'h1C,  0, 32'h18,  NOP};
      vecs[11] = '{0, 0, 1, 1, 32'h203, 1, 32'h1C,  0, 32'h18,  NOP};
      vecs[12] = '{0, 0, 0, 0, 32'h0,   1, 32'h200, 1, 32'h200, word_of(32'h200)};

      do_reset();
      lat = 0;
      for (int i = 0; i < 13; i++) begin
         set_in(vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].ps, vecs[i].tgt);
         #1;
         check($sformatf("vec%0d.imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
         check($sformatf("vec%0d.imem_addr", i), imem_addr, vecs[i].e_addr);
         step();
         check_ifid($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_pc, vecs[i].e_instr);
      end
      set_in(0, 0, 0, 0, 32'd0);

      // 3-cycle latency: three bubbles per instruction, address held while waiting
      lat = 3;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < 4; c++) begin
            check($sformatf("lat3.%0d.%0d.addr", k, c), imem_addr, 32'h204 + 32'(4 * k));
            check($sformatf("lat3.%0d.%0d.req", k, c), {31'd0, imem_req}, 32'd1);
            step();
            if (c < 3) begin
               check($sformatf("lat3.%0d.%0d.ValidD", k, c), {31'd0, ValidD}, 32'd0);
               check($sformatf("lat3.%0d.%0d.InstrD", k, c), InstrD, NOP);
            end else begin
               check_ifid($sformatf("lat3.%0d", k), 1'b1, 32'h204 + 32'(4 * k),
                          word_of(32'h204 + 32'(4 * k)));
            end
         end
      end

      // Response lands during a 2-cycle stallF/stallD window
      lat = 2;
      step();
      step();
      set_in(1, 1, 0, 0, 32'd0);
      #1;
      check("hold.resp_req", {31'd0, imem_req}, 32'd1);
      check("hold.resp_addr", imem_addr, 32'h20C);
      step();
      check_ifid("hold.c2", 1'b0, 32'h208, NOP);
      spurious = 1'b1;
      #1;
      check("hold.req_low", {31'd0, imem_req}, 32'd0);
      check("hold.state", {30'd0, state_dbg}, 32'd1);
      step();
      spurious = 1'b0;
      check_ifid("hold.c3", 1'b0, 32'h208, NOP);
      set_in(0, 0, 0, 0, 32'd0);
      #1;
      check("hold.release_req", {31'd0, imem_req}, 32'd0);
      step();
      check_ifid("hold.release", 1'b1, 32'h20C, word_of(32'h20C));
      check("hold.next_addr", imem_addr, 32'h210);
      check("hold.next_req", {31'd0, imem_req}, 32'd1);
      step();
      step();
      step();
      check_ifid("hold.next", 1'b1, 32'h210, word_of(32'h210));

      // Redirect while a 4-cycle request to 0x10 is outstanding
      do_reset();
      lat = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_ifid($sformatf("seq.%0d", i), 1'b1, 32'(4 * i), word_of(32'(4 * i)));
      end
      lat = 4;
      check("drain.launch_addr", imem_addr, 32'h10);
      step();
      set_in(0, 0, 1, 1, 32'h0000_0103);
      #1;
      check("drain.redirect_req", {31'd0, imem_req}, 32'd1);
      step();
      set_in(0, 0, 0, 0, 32'd0);
      check("drain.state", {30'd0, state_dbg}, 32'd2);
      check("drain.stale_addr", imem_addr, 32'h10);
      check("drain.stale_req", {31'd0, imem_req}, 32'd1);
      step();
      step();
      step();
      check("drain.dropped_valid", {31'd0, ValidD}, 32'd0);
      check("drain.dropped_instr", InstrD, NOP);
      lat = 0;
      #1;
      check("drain.new_addr", imem_addr, 32'h100);
      check("drain.new_req", {31'd0, imem_req}, 32'd1);
      step();
      check_ifid("drain.first", 1'b1, 32'h100, word_of(32'h100));

      // Asynchronous reset in the middle of a slow request
      lat = 5;
      step();
      step();
      check("areset.pre_req", {31'd0, imem_req}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_vals("areset");
      step();
      reset = 1'b0;
      lat = 0;
      #1;
      check("areset.restart_req", {31'd0, imem_req}, 32'd1);
      check("areset.restart_addr", imem_addr, 32'h0);
      step();
      check_ifid("areset.first", 1'b1, 32'h0, word_of(32'h0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
